// File: rtl/gjy_uart.sv
// rtl/gjy_uart.sv - ICB-attached UART with programmable 16x-oversampled baud, parity and RX/TX flags.
// Define GJY_UART_IRQ_EN to drive io_interrupts_0_0 = tx_ok | rx_ok; otherwise it is tied to 0.
module gjy_uart #(
  parameter int          PA_SIZE = 32,
  parameter logic [15:0] DIV_RST = 16'h0008
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_icb_cmd_valid,
  output logic               i_icb_cmd_ready,
  input  logic [PA_SIZE-1:0] i_icb_cmd_addr,
  input  logic               i_icb_cmd_read,
  input  logic [31:0]        i_icb_cmd_wdata,
  output logic               i_icb_rsp_valid,
  input  logic               i_icb_rsp_ready,
  output logic [31:0]        i_icb_rsp_rdata,
  output logic               io_interrupts_0_0,
  output logic               io_port_txd,
  input  logic               io_port_rxd
);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

  logic [15:0] div;
  logic [19:0] ctrl;
  logic        baud_en, tx_en, rx_en, no_parity, ev_parity;
  logic        tx_ok, rx_ok, rx_perr, rx_ferr;
  logic [7:0]  rx_data;
  logic [1:0]  reg_sel;
  logic        csr_rd, csr_wr, ctrl_wr, data_wr;
  logic [31:0] rd_mux;
  logic        unused_sigs;

  assign baud_en   = ctrl[0];
  assign tx_en     = ctrl[4];
  assign rx_en     = ctrl[8];
  assign no_parity = ctrl[12];
  assign ev_parity = ctrl[16];

  assign i_icb_cmd_ready = 1'b1;
  assign reg_sel = i_icb_cmd_addr[3:2];
  assign csr_rd  = i_icb_cmd_valid &  i_icb_cmd_read & (reg_sel == 2'd0);
  assign csr_wr  = i_icb_cmd_valid & ~i_icb_cmd_read & (reg_sel == 2'd0);
  assign ctrl_wr = i_icb_cmd_valid & ~i_icb_cmd_read & (reg_sel == 2'd1);
  assign data_wr = i_icb_cmd_valid & ~i_icb_cmd_read & (reg_sel == 2'd2);
  assign unused_sigs = ^{i_icb_rsp_ready, i_icb_cmd_addr};

  // Baud divider: one tick16 every DIV+1 clocks; >= keeps it sane if DIV shrinks mid-count.
  logic [15:0] baud_cnt;
  logic        tick;
  assign tick = baud_en && (baud_cnt >= div);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                baud_cnt <= '0;
    else if (!baud_en || tick) baud_cnt <= '0;
    else                      baud_cnt <= baud_cnt + 16'd1;
  end

  tx_state_t  tx_state, tx_next;
  logic [3:0] tx_tcnt, tx_tcnt_next;
  logic [2:0] tx_bit, tx_bit_next;
  logic [7:0] tx_byte, tx_byte_next;
  logic       txd_next, tx_done, tx_bit_end, tx_busy;

  assign tx_bit_end = tick && (tx_tcnt == 4'd15);
  assign tx_busy    = (tx_state != TX_IDLE);

  always_comb begin
    tx_next      = tx_state;
    tx_tcnt_next = tx_tcnt;
    tx_bit_next  = tx_bit;
    tx_byte_next = tx_byte;
    tx_done      = 1'b0;
    txd_next     = 1'b1;
    if (tx_state != TX_IDLE && tick) tx_tcnt_next = tx_tcnt + 4'd1;
    case (tx_state)
      TX_IDLE: begin
        if (data_wr && tx_en) begin
          tx_next      = TX_START;
          tx_tcnt_next = 4'd0;
          tx_bit_next  = 3'd0;
          tx_byte_next = i_icb_cmd_wdata[7:0];
        end
      end
      TX_START: if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_bit_next = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_next = no_parity ? TX_STOP : TX_PAR;
        end
      end
      TX_PAR:  if (tx_bit_end) tx_next = TX_STOP;
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_next = TX_IDLE;
          tx_done = 1'b1;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
    // Line level follows the state being entered so txd stays a clean flop output.
    case (tx_next)
      TX_START: txd_next = 1'b0;
      TX_DATA:  txd_next = tx_byte_next[tx_bit_next];
      TX_PAR:   txd_next = ev_parity ? ^tx_byte_next : ~^tx_byte_next;
      default:  txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tx_state    <= TX_IDLE;
      tx_tcnt     <= '0;
      tx_bit      <= '0;
      tx_byte     <= '0;
      io_port_txd <= 1'b1;
    end else begin
      tx_state    <= tx_next;
      tx_tcnt     <= tx_tcnt_next;
      tx_bit      <= tx_bit_next;
      tx_byte     <= tx_byte_next;
      io_port_txd <= txd_next;
    end
  end

  logic       rx_s1, rx_s2, rx_s3, rx_fall;
  rx_state_t  rx_state, rx_next;
  logic [3:0] rx_tcnt, rx_tcnt_next;
  logic [2:0] rx_bit, rx_bit_next;
  logic [7:0] rx_shift, rx_shift_next;
  logic       rx_pbad, rx_pbad_next;
  logic       rx_sample, rx_bit_end, rx_done, rx_perr_set, rx_ferr_set;

  assign rx_fall    = rx_s3 & ~rx_s2;
  assign rx_sample  = tick && (rx_tcnt == 4'd8);
  assign rx_bit_end = tick && (rx_tcnt == 4'd15);

  always_comb begin
    rx_next       = rx_state;
    rx_tcnt_next  = rx_tcnt;
    rx_bit_next   = rx_bit;
    rx_shift_next = rx_shift;
    rx_pbad_next  = rx_pbad;
    rx_done       = 1'b0;
    rx_perr_set   = 1'b0;
    rx_ferr_set   = 1'b0;
    if (rx_state != RX_IDLE && tick) rx_tcnt_next = rx_tcnt + 4'd1;
    if (!rx_en) begin
      rx_next = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_next      = RX_START;
            rx_tcnt_next = 4'd0;
            rx_bit_next  = 3'd0;
            rx_pbad_next = 1'b0;
          end
        end
        RX_START: begin
          if (rx_sample && rx_s2) rx_next = RX_IDLE;
          else if (rx_bit_end)    rx_next = RX_DATA;
        end
        RX_DATA: begin
          if (rx_sample) rx_shift_next = {rx_s2, rx_shift[7:1]};
          if (rx_bit_end) begin
            rx_bit_next = rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_next = no_parity ? RX_STOP : RX_PAR;
          end
        end
        RX_PAR: begin
          if (rx_sample) rx_pbad_next = rx_s2 != (ev_parity ? ^rx_shift : ~^rx_shift);
          if (rx_bit_end) rx_next = RX_STOP;
        end
        RX_STOP: begin
          // Finish at mid-stop so the next start edge is never missed.
          if (rx_sample) begin
            rx_next     = RX_IDLE;
            rx_done     = 1'b1;
            rx_perr_set = rx_pbad & ~no_parity;
            rx_ferr_set = ~rx_s2;
          end
        end
        default: rx_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_pbad  <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_s1    <= io_port_rxd;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_next;
      rx_tcnt  <= rx_tcnt_next;
      rx_bit   <= rx_bit_next;
      rx_shift <= rx_shift_next;
      rx_pbad  <= rx_pbad_next;
      if (rx_done) rx_data <= rx_shift;
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    case (reg_sel)
      2'd0:    rd_mux = {div, 9'h0, rx_ferr, rx_perr, rx_ok, 2'b00, tx_busy, tx_ok};
      2'd1:    rd_mux = {12'h0, ctrl};
      2'd2:    rd_mux = {24'h0, rx_data};
      default: rd_mux = 32'h0;
    endcase
  end

  // Flags: a hardware set on the same edge as a read-clear wins.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      div             <= DIV_RST;
      ctrl            <= '0;
      tx_ok           <= 1'b0;
      rx_ok           <= 1'b0;
      rx_perr         <= 1'b0;
      rx_ferr         <= 1'b0;
      i_icb_rsp_valid <= 1'b0;
      i_icb_rsp_rdata <= '0;
    end else begin
      i_icb_rsp_valid <= i_icb_cmd_valid;
      if (i_icb_cmd_valid && i_icb_cmd_read) i_icb_rsp_rdata <= rd_mux;
      if (csr_wr)  div  <= i_icb_cmd_wdata[31:16];
      if (ctrl_wr) ctrl <= i_icb_cmd_wdata[19:0];
      tx_ok   <= tx_done     | (tx_ok   & ~csr_rd);
      rx_ok   <= rx_done     | (rx_ok   & ~csr_rd);
      rx_perr <= rx_perr_set | (rx_perr & ~csr_rd);
      rx_ferr <= rx_ferr_set | (rx_ferr & ~csr_rd);
    end
  end

`ifdef GJY_UART_IRQ_EN
  assign io_interrupts_0_0 = tx_ok | rx_ok;
`else
  assign io_interrupts_0_0 = 1'b0;
`endif

endmodule

// File: tb/tb_gjy_uart.sv
// tb/tb_gjy_uart.sv - scoreboard bench for gjy_uart: bus responses and TX frames checked against a reference model.
module tb_gjy_uart;

  localparam logic [1:0] A_CSR = 2'd0, A_CTRL = 2'd1, A_DATA = 2'd2, A_RSV = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_read, rsp_valid, rsp_ready, irq, txd, rxd;
  logic [31:0] cmd_addr, cmd_wdata, rsp_rdata;
  logic        loopback, tb_rxd;

  always #5 clk = ~clk;
  assign rxd = loopback ? txd : tb_rxd;

  gjy_uart dut (
    .clk(clk), .rst_n(rst_n),
    .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(cmd_ready),
    .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_read(cmd_read), .i_icb_cmd_wdata(cmd_wdata),
    .i_icb_rsp_valid(rsp_valid), .i_icb_rsp_ready(rsp_ready), .i_icb_rsp_rdata(rsp_rdata),
    .io_interrupts_0_0(irq), .io_port_txd(txd), .io_port_rxd(rxd)
  );

  typedef struct { logic [7:0] b; bit np; bit ev; } frm_t;

  logic [31:0] exp_q[$];
  string       nm_q[$];
  frm_t        tx_q[$];
  int          checks = 0, errors = 0, frames_seen = 0, nframes = 0;
  logic [15:0] cur_div;
  bit          cur_np, cur_ev, mon_en;
  logic [31:0] last_rd;
`ifdef GJY_UART_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic bit par_bit(input logic [7:0] b, input bit ev);
    int ones;
    ones = $countones(b);
    return ev ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit np, input bit ev);
    if (np) return {1'b0, 1'b1, b, 1'b0};
    return {1'b1, par_bit(b, ev), b, 1'b0};
  endfunction

  function automatic logic [31:0] csr_v(input logic [15:0] dv, input bit txok, input bit busy,
                                        input bit rxok, input bit perr, input bit ferr);
    logic [31:0] r;
    r = {dv, 16'h0};
    r[0] = txok; r[1] = busy; r[4] = rxok; r[5] = perr; r[6] = ferr;
    return r;
  endfunction

  function automatic logic [31:0] ctrl_v(input bit np, input bit ev);
    return {15'h0, ev, 3'h0, np, 12'h111};
  endfunction

  task automatic bus_rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    exp_q.push_back(exp); nm_q.push_back(nm); last_rd = exp;
    cmd_addr = {28'h0, a, 2'b00}; cmd_read = 1'b1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    exp_q.push_back(last_rd); nm_q.push_back("wr_hold");
    cmd_addr = {28'h0, a, 2'b00}; cmd_read = 1'b0; cmd_wdata = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_tx(input logic [7:0] b);
    frm_t f;
    f.b = b; f.np = cur_np; f.ev = cur_ev;
    tx_q.push_back(f);
    nframes++;
    bus_wr(A_DATA, {24'h0, b});
  endtask

  task automatic wait_frames();
    int budget;
    budget = 20000;
    while (frames_seen < nframes && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (frames_seen < nframes) begin
      checks++; errors++;
      $display("FAIL frame_timeout seen=%0d expected=%0d", frames_seen, nframes);
    end
    repeat (16 * (int'(cur_div) + 1)) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit pbit, input bit stop);
    int bc;
    logic [10:0] bits;
    bc = 16 * (int'(cur_div) + 1);
    bits = {stop, pbit, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      tb_rxd = bits[i];
      repeat (bc) @(posedge clk);
    end
    #1; tb_rxd = 1'b1;
    repeat (bc) @(posedge clk);
    #1;
  endtask

  initial begin : rsp_mon
    logic [31:0] e;
    string n;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) check("rsp_spurious", 32'(rsp_valid), 32'h0);
        else begin
          e = exp_q.pop_front(); n = nm_q.pop_front();
          check(n, rsp_rdata, e);
        end
      end
    end
  end

  initial begin : tx_mon
    logic prev;
    logic [10:0] got;
    frm_t f;
    int bc, nb;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev === 1'b1 && txd === 1'b0) begin
        bc = 16 * (int'(cur_div) + 1);
        nb = cur_np ? 10 : 11;
        got = '0;
        repeat (bc / 2) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
          got[i] = txd;
          if (i < nb - 1) repeat (bc) @(negedge clk);
        end
        if (tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected frame=%h expected=none", got);
        end else begin
          f = tx_q.pop_front();
          check("tx_frame", {21'h0, got}, {21'h0, frame_bits(f.b, f.np, f.ev)});
        end
        frames_seen++;
      end
      prev = txd;
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] r;
    logic [7:0]  b;
    logic [15:0] dv;
    bit          np, ev, pb;
    cmd_valid = 0; cmd_read = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 1;
    loopback = 1; tb_rxd = 1; mon_en = 1;
    cur_div = 16'h0008; cur_np = 0; cur_ev = 0; last_rd = 0;

    rst_n = 0; #2 rst_n = 1;
    repeat (3) @(posedge clk); #1;
    check("rst_txd", 32'(txd), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst_n = 0;
    @(posedge clk); #1;
    bus_rd(A_CSR, csr_v(16'h0008, 0, 0, 0, 0, 0), "rst_csr");
    bus_rd(A_CTRL, 32'h0, "rst_ctrl");
    bus_rd(A_RSV, 32'h0, "reserved_rd");
    r = $urandom;
    bus_wr(A_CTRL, r);
    bus_rd(A_CTRL, r & 32'h000F_FFFF, "ctrl_20bit");
    bus_wr(A_RSV, $urandom);
    bus_rd(A_CTRL, r & 32'h000F_FFFF, "reserved_wr_ignored");

    // A5 with even parity at DIV=8: 144-clock bits.
    bus_wr(A_CSR, {16'h0008, 16'($urandom)});
    cur_div = 16'h0008;
    cur_np = 0; cur_ev = 1;
    bus_wr(A_CTRL, ctrl_v(0, 1));
    send_tx(8'hA5);
    wait_frames();
    check("irq_set", 32'(irq), 32'(IRQ_ON));
    bus_rd(A_CSR, csr_v(16'h0008, 1, 0, 1, 0, 0), "csr_after_tx");
    bus_rd(A_CSR, csr_v(16'h0008, 0, 0, 0, 0, 0), "csr_cleared");
    check("irq_clear", 32'(irq), 32'h0);
    bus_rd(A_DATA, 32'h0000_00A5, "loop_data_a5");

    for (int k = 0; k < 10; k++) begin
      dv = 16'($urandom_range(0, 3));
      np = 1'($urandom_range(0, 1));
      ev = 1'($urandom_range(0, 1));
      b  = 8'($urandom);
      bus_wr(A_CSR, {dv, 16'($urandom)});
      cur_div = dv; cur_np = np; cur_ev = ev;
      bus_wr(A_CTRL, ctrl_v(np, ev));
      send_tx(b);
      wait_frames();
      bus_rd(A_CSR, csr_v(dv, 1, 0, 1, 0, 0), "loop_csr");
      bus_rd(A_DATA, {24'h0, b}, "loop_data");
    end

    // Second DATA write while busy must be dropped.
    bus_wr(A_CSR, {16'h0001, 16'h0});
    cur_div = 16'h0001; cur_np = 0; cur_ev = 0;
    bus_wr(A_CTRL, ctrl_v(0, 0));
    send_tx(8'h3C);
    bus_rd(A_CSR, csr_v(16'h0001, 0, 1, 0, 0, 0), "csr_busy");
    bus_wr(A_DATA, 32'h0000_00C3);
    wait_frames();
    bus_rd(A_CSR, csr_v(16'h0001, 1, 0, 1, 0, 0), "busy_csr_done");
    bus_rd(A_DATA, 32'h0000_003C, "busy_data");
    repeat (500) @(posedge clk); #1;
    check("no_second_frame", 32'(frames_seen), 32'(nframes));

    // BAUD_EN=0 freezes TX in START until enabled.
    mon_en = 0;
    bus_wr(A_CTRL, 32'h0000_0010);
    bus_wr(A_DATA, 32'h0000_005A);
    repeat (300) @(posedge clk); #1;
    check("baud_off_txd", 32'(txd), 32'h0);
    bus_rd(A_CSR, csr_v(16'h0001, 0, 1, 0, 0, 0), "baud_off_busy");
    bus_wr(A_CTRL, 32'h0000_0011);
    repeat (12 * 32 + 40) @(posedge clk); #1;
    bus_rd(A_CSR, csr_v(16'h0001, 1, 0, 0, 0, 0), "baud_on_done");
    check("baud_on_txd", 32'(txd), 32'h1);
    mon_en = 1;

    // Direct RX frames at DIV=8, even parity.
    loopback = 0;
    bus_wr(A_CSR, {16'h0008, 16'h0});
    cur_div = 16'h0008;
    bus_wr(A_CTRL, ctrl_v(0, 1));
    pb = par_bit(8'h3C, 1);
    send_rx(8'h3C, pb, 1'b1);
    check("rx_irq", 32'(irq), 32'(IRQ_ON));
    bus_rd(A_CSR, csr_v(16'h0008, 0, 0, 1, 0, 0), "rx_csr_good");
    bus_rd(A_DATA, 32'h0000_003C, "rx_data_good");
    send_rx(8'h3C, ~pb, 1'b1);
    bus_rd(A_CSR, csr_v(16'h0008, 0, 0, 1, 1, 0), "rx_csr_perr");
    b = 8'($urandom);
    send_rx(b, par_bit(b, 1), 1'b0);
    bus_rd(A_CSR, csr_v(16'h0008, 0, 0, 1, 0, 1), "rx_csr_ferr");
    bus_rd(A_DATA, {24'h0, b}, "rx_data_ferr");
    tb_rxd = 0;
    repeat (5 * 9) @(posedge clk); #1;
    tb_rxd = 1;
    repeat (3 * 144) @(posedge clk); #1;
    bus_rd(A_CSR, csr_v(16'h0008, 0, 0, 0, 0, 0), "rx_glitch_csr");
    bus_rd(A_DATA, {24'h0, b}, "rx_glitch_data");

    // Reset mid-frame returns txd high at once.
    loopback = 1; mon_en = 0;
    bus_wr(A_DATA, 32'h0000_00FF);
    repeat (50) @(posedge clk); #1;
    check("mid_frame_txd", 32'(txd), 32'h0);
    rst_n = 1; #1;
    check("rst_mid_txd", 32'(txd), 32'h1);
    check("rst_mid_rdata", rsp_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 0; last_rd = 0;
    @(posedge clk); #1;
    bus_rd(A_CTRL, 32'h0, "rst_mid_ctrl");
    bus_rd(A_CSR, csr_v(16'h0008, 0, 0, 0, 0, 0), "rst_mid_csr");

    repeat (5) @(posedge clk); #1;
    check("tx_q_empty", 32'(tx_q.size()), 32'h0);
    check("rsp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gjy_uart.md
Name: gjy_uart

Overview:
- UART peripheral with an ICB slave register interface.
- Converts bus writes into serial frames on io_port_txd and deserializes io_port_rxd into a readable data register.
- Baud rate comes from a programmable divisor with 16x oversampling.
- Provides a level interrupt for TX-done and RX-done events; sits on the SoC peripheral bus.

Parameters:
- PA_SIZE, 32, address width of i_icb_cmd_addr.
- DIV_RST, 16'h0008, reset value of the baud divisor field.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-high: asserted when 1, despite the name.
- i_icb_cmd_valid  in  1  command valid.
- i_icb_cmd_ready  out  1  command ready; constant 1.
- i_icb_cmd_addr  in  PA_SIZE  byte address; decode addr[3:2].
- i_icb_cmd_read  in  1  1=read, 0=write.
- i_icb_cmd_wdata  in  32  write data.
- i_icb_rsp_valid  out  1  response valid.
- i_icb_rsp_ready  in  1  response ready; ignored, no backpressure.
- i_icb_rsp_rdata  out  32  read data, registered.
- io_interrupts_0_0  out  1  level interrupt.
- io_port_txd  out  1  serial TX, idle high.
- io_port_rxd  in  1  serial RX; synchronize with 2 flops.

Behaviour:
- Register map, by addr[3:2]; 3 is reserved (reads 0, writes ignored):
  - 0 = CSR (UART_CSR_ADDR)
  - 1 = CTRL (UART_CTRL_ADDR)
  - 2 = DATA (DATA_REG_ADDR)
- CSR fields:
  - [31:16] DIV, RW.
  - [0] tx_ok, RO; read-to-clear.
  - [1] tx_busy, RO.
  - [4] rx_ok, RO; read-to-clear.
  - [5] rx_perr, RO; read-to-clear.
  - [6] rx_ferr (stop bit sampled 0), RO; read-to-clear.
  - Other bits read 0.
- CTRL (RW; only bit 0 of each nibble is used):
  - bit0 BAUD_EN, bit4 TX_EN, bit8 RX_EN, bit12 NO_PARITY, bit16 EV_PARITY.
  - Reads return the full 20-bit value written.
- DATA:
  - Write: if TX_EN=1 and tx idle, load wdata[7:0] and start a frame; otherwise the write is dropped.
  - Read: {24'b0, last received byte}.
- Bus timing:
  - Command accepted on any clk edge with cmd_valid=1 (cmd_ready is always 1).
  - rsp_valid=1 for exactly the following cycle.
  - rsp_rdata is loaded at the accepting edge (nonblocking, so it is valid just after that edge).
  - rsp_rdata is held until the next accepted read; writes leave it unchanged.
- Read-to-clear: CSR flags captured into rsp_rdata are cleared at the same edge. If a hardware set coincides with the clear, the set wins.
- Baud tick: counter runs 0..DIV and emits a 1-cycle tick16 when it wraps, giving a bit rate of f_clk/(16*(DIV+1)). With BAUD_EN=0 the counter is held at 0, no ticks are produced, and TX/RX freeze in place.
- Frame format:
  - Start bit 0, then 8 data bits LSB first.
  - Parity bit only if NO_PARITY=0: even if EV_PARITY=1, odd otherwise.
  - One stop bit 1.
  - Each bit lasts 16 tick16.
- TX FSM: IDLE -> START -> DATA(8) -> PARITY (skipped if NO_PARITY) -> STOP -> IDLE.
  - tx_busy=1 outside IDLE.
  - tx_ok is set at the end of STOP.
- RX FSM: IDLE -> START -> DATA -> PARITY -> STOP.
  - Enabled only when RX_EN=1.
  - IDLE -> START on falling edge of the synchronized RX.
  - Start bit is re-checked at count 8; if it is high, return to IDLE (glitch).
  - Each bit is sampled at count 8.
  - At the stop-bit sample, load DATA, set rx_ok, and set rx_perr/rx_ferr as applicable.
  - A new frame overwrites DATA; there is no overrun flag.
- Interrupt: io_interrupts_0_0 = tx_ok | rx_ok.
- Reset values:
  - txd=1, rsp_valid=0, rsp_rdata=0, interrupt=0.
  - CTRL=0, DIV=DIV_RST, all flags 0, FSMs in IDLE.
- Asserting reset mid-frame aborts the frame immediately and returns txd to 1.
- Writing CTRL or DIV mid-frame takes effect immediately (software must avoid doing this).

Optional Feature:
- Macro: GJY_UART_IRQ_EN.
- Defined: io_interrupts_0_0 behaves as specified above.
- Undefined: io_interrupts_0_0 is tied to 0 and no interrupt logic is instantiated; flags remain pollable via CSR.

Test Plan:
- 16 MHz clock: write CSR=32'h0008_0000, CTRL=32'h1_0111 (even parity), DATA=8'hA5 -> txd frame 0,1,0,1,0,0,1,0,1,0,1 with bit period 9 clk*16 = 144 clk; tx_ok set, first CSR read bit0=1, next read 0.
- Loopback rxd=txd, 256 bytes from data.hex at 115200 -> each DATA read equals the sent byte; rx_ok (bit4) pulses per byte; zero mismatches.
- RX stimulus at 8681 ns/bit with even parity, byte 8'h3C, parity 0 -> CSR bit4=1, DATA read 32'h3C, rx_perr=0; same frame with parity 1 -> rx_perr=1.
- 144 MHz clock with DIV=0x3A9 -> bit period 938*16 clk (~104.2 us) on txd.
- BAUD_EN=0 with DATA written -> txd stays low in START, no progress; set BAUD_EN=1 -> frame completes.
- Write DATA while tx_busy=1 -> second byte dropped; only the first frame is transmitted.
